// File: rtl/pwm_duty_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_duty_scheduler
// Purpose  : Multi-channel duty-cycle scheduler in front of a PWM generator
//            bank. Takes duty commands over a valid/ready handshake and
//            applies them only at PWM period boundaries, so a generator
//            never sees its duty change mid-period. With the optional slew
//            limiter, each channel moves at most STEP per period.
// Options  : define PWM_SLEW_LIMIT_EN to enable per-channel slew limiting;
//            when undefined, a new target lands in full at the next commit
//            and STEP is ignored.
// Ports    :
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   cmd_valid    in   command present
//   cmd_ready    out  high in RUN while out of reset; accept = valid & ready
//   cmd_ch       in   target channel (values >= N_CH are accepted, dropped)
//   cmd_duty     in   requested duty (clamped to MAX_DUTY)
//   duty_out     out  committed duty, channel k in bits [8k+7:8k]
//   period_tick  out  one-cycle pulse while the period counter is PERIOD-1
//   busy         out  high while any committed duty differs from its target
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_scheduler #(
  parameter int N_CH     = 4,
  parameter int PERIOD   = 2500,
  parameter int STEP     = 5,
  parameter int MAX_DUTY = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [7:0]        cmd_duty,
  output logic [8*N_CH-1:0] duty_out,
  output logic              period_tick,
  output logic              busy
);

  localparam int c_CNT_W = $clog2(PERIOD);
  localparam int c_IDX_W = $clog2(N_CH);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(PERIOD - 2);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_CH - 1);
  localparam logic [7:0]         c_MAX8     = 8'(MAX_DUTY);
  localparam logic [3:0]         c_NCH4     = 4'(N_CH);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_SCAN   = 2'd1;
  localparam logic [1:0] c_ST_COMMIT = 2'd2;

  // Elaboration-time guard on the parameter ranges the scheduler relies on.
  if (N_CH < 2 || N_CH > 8 || PERIOD <= N_CH + 2 || STEP < 1 || STEP > 250 ||
      MAX_DUTY < 0 || MAX_DUTY > 255) begin : g_bad_param
    $error("pwm_duty_scheduler: parameter out of range");
  end

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tick;
  logic [1:0]         r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_busy;
  logic [N_CH-1:0]    w_diff;
  logic               w_accept;
  logic               w_ch_ok;
  logic [7:0]         w_cmd_clamped;

  // --------------------------------------------------------------------------
  // Period counter. The tick register is loaded one count early so that it
  // is high exactly while the counter holds PERIOD-1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == c_CNT_PRE);
    end
  end

  // --------------------------------------------------------------------------
  // RUN -> SCAN (N_CH cycles, one channel each) -> COMMIT (1 cycle) -> RUN.
  // A command accepted on the tick cycle writes its target on the same edge
  // that enters SCAN, so the scan already sees it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_RUN;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_ST_RUN: begin
          if (r_tick) begin
            r_state <= c_ST_SCAN;
            r_idx   <= '0;
          end
        end
        c_ST_SCAN: begin
          if (r_idx == c_IDX_LAST) begin
            r_state <= c_ST_COMMIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        c_ST_COMMIT: begin
          r_state <= c_ST_RUN;
        end
        default: begin
          r_state <= c_ST_RUN;
        end
      endcase
    end
  end

  // Ready drops combinationally with reset so nothing is taken during reset.
  assign cmd_ready     = (r_state == c_ST_RUN) && reset;
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_ch_ok       = ({1'b0, cmd_ch} < c_NCH4);
  assign w_cmd_clamped = (cmd_duty > c_MAX8) ? c_MAX8 : cmd_duty;

  // --------------------------------------------------------------------------
  // Per-channel target / working copy / committed duty.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [7:0] r_target;
    logic [7:0] r_cur;
    logic [7:0] r_duty;
    logic [7:0] w_cur_next;

`ifdef PWM_SLEW_LIMIT_EN
    // Slew step in 9 bits so cur+STEP and target+STEP cannot wrap. The
    // result always lies between cur and target, so it stays within
    // 0..MAX_DUTY.
    localparam logic [8:0] c_STEP9 = 9'(STEP);
    localparam logic [7:0] c_STEP8 = 8'(STEP);
    logic [8:0] w_up;
    logic [8:0] w_dn_floor;

    always_comb begin
      w_up       = {1'b0, r_cur} + c_STEP9;
      w_dn_floor = {1'b0, r_target} + c_STEP9;
      w_cur_next = r_cur;
      if (r_target > r_cur) begin
        w_cur_next = (w_up > {1'b0, r_target}) ? r_target : w_up[7:0];
      end else if (r_target < r_cur) begin
        // cur >= target + STEP guarantees cur >= STEP, so no underflow.
        w_cur_next = ({1'b0, r_cur} < w_dn_floor) ? r_target
                                                  : (r_cur - c_STEP8);
      end
    end
`else
    always_comb begin
      w_cur_next = r_target;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_target <= 8'd0;
        r_cur    <= 8'd0;
        r_duty   <= 8'd0;
      end else begin
        if (w_accept && w_ch_ok && (cmd_ch == 3'(k))) begin
          r_target <= w_cmd_clamped;
        end
        if ((r_state == c_ST_SCAN) && (r_idx == c_IDX_W'(k))) begin
          r_cur <= w_cur_next;
        end
        // All channels load together, only in COMMIT.
        if (r_state == c_ST_COMMIT) begin
          r_duty <= r_cur;
        end
      end
    end

    assign duty_out[8*k +: 8] = r_duty;
    assign w_diff[k]          = (r_duty != r_target);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_diff;
    end
  end

  assign period_tick = r_tick;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_scheduler
// Purpose  : Directed self-checking bench for pwm_duty_scheduler with the
//            default parameters (4 channels, 2500-cycle period, STEP 5).
//            Expected values follow PWM_SLEW_LIMIT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_scheduler;

  localparam int N_CH   = 4;
  localparam int PERIOD = 2500;
`ifdef PWM_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic              clock     = 1'b0;
  logic              reset     = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd_ch    = 3'd0;
  logic [7:0]        cmd_duty  = 8'd0;
  logic              cmd_ready;
  logic [8*N_CH-1:0] duty_out;
  logic              period_tick;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pwm_duty_scheduler #(
    .N_CH     (N_CH),
    .PERIOD   (PERIOD),
    .STEP     (5),
    .MAX_DUTY (250)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_duty    (cmd_duty),
    .duty_out    (duty_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the bench on the falling edge inside the tick cycle.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (period_tick !== 1'b1 && n < 3000);
    chk("tick_seen", {31'd0, period_tick}, 32'd1);
  endtask

  // Presents one command for a single cycle, from a falling edge in RUN.
  task automatic send(input logic [2:0] ch, input logic [7:0] duty);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_duty  = duty;
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_duty", duty_out, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    skip(2);
    reset = 1'b1;
  endtask

  initial begin
    int         n;
    logic [7:0] prev;
    logic [7:0] exp;

    // ---------------- reset values and idle behaviour ----------------
    skip(3);
    chk("reset_duty", duty_out, 32'd0);
    chk("reset_tick", {31'd0, period_tick}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    skip(1);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    wait_tick(n);
    chk("first_tick_latency", n, 32'(PERIOD - 2));
    for (int i = 1; i <= 6; i++) begin
      skip(1);
      chk("idle_scan_ready", {31'd0, cmd_ready}, (i <= 5) ? 32'd0 : 32'd1);
    end
    chk("idle_duty", duty_out, 32'd0);
    skip(1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    wait_tick(n);
    chk("tick_interval", n, 32'(PERIOD - 7));

    // ---------------- ch1 <- 20, ramp or step ----------------
    skip(94);
    send(3'd1, 8'd20);
    skip(2);
    chk("A_busy_up", {31'd0, busy}, 32'd1);
    prev = 8'd0;
    for (int p = 0; p < 4; p++) begin
      exp = SLEW ? 8'(5 * (p + 1)) : 8'd20;
      wait_tick(n);
      skip(5);
      chk("A_hold", duty_out, {16'd0, prev, 8'd0});
      skip(1);
      chk("A_commit", duty_out, {16'd0, exp, 8'd0});
      skip(1);
      chk("A_busy", {31'd0, busy}, (SLEW && p < 3) ? 32'd1 : 32'd0);
      prev = exp;
    end

    // ---------------- last command in a period wins ----------------
    do_reset();
    wait_tick(n);
    skip(10);
    send(3'd2, 8'd250);
    send(3'd2, 8'd0);
    skip(2);
    chk("B_busy_last_wins", {31'd0, busy}, 32'd0);
    wait_tick(n);
    skip(6);
    chk("B_no_250", duty_out, 32'd0);
    skip(10);
    send(3'd2, 8'd249);
    wait_tick(n);
    skip(5);
    chk("B_hold", duty_out, 32'd0);
    skip(1);
    chk("B_commit", duty_out, {8'd0, (SLEW ? 8'd5 : 8'd249), 16'd0});
    skip(1);
    chk("B_busy", {31'd0, busy}, SLEW ? 32'd1 : 32'd0);

    // ---------------- clamp and out-of-range channel ----------------
    do_reset();
    wait_tick(n);
    skip(10);
    send(3'd0, 8'd255);
    send(3'd6, 8'd77);
    wait_tick(n);
    skip(6);
    chk("C_clamp", duty_out, {24'd0, (SLEW ? 8'd5 : 8'd250)});
    skip(1);
    chk("C_busy", {31'd0, busy}, SLEW ? 32'd1 : 32'd0);

    // ---------------- valid held from the tick cycle ----------------
    do_reset();
    wait_tick(n);
    chk("D_ready_tick", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_ch    = 3'd3;
    cmd_duty  = 8'd100;
    for (int i = 1; i <= 5; i++) begin
      skip(1);
      chk("D_ready_stall", {31'd0, cmd_ready}, 32'd0);
    end
    skip(1);
    chk("D_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("D_tick_cmd_applied", duty_out, {(SLEW ? 8'd5 : 8'd100), 24'd0});
    skip(1);
    cmd_valid = 1'b0;
    chk("D_busy", {31'd0, busy}, SLEW ? 32'd1 : 32'd0);

    // ---------------- reset in the 2nd SCAN cycle ----------------
    wait_tick(n);
    chk("E_pre", duty_out, {(SLEW ? 8'd5 : 8'd100), 24'd0});
    skip(2);
    reset = 1'b0;
    #1;
    chk("E_rst_duty", duty_out, 32'd0);
    chk("E_rst_busy", {31'd0, busy}, 32'd0);
    chk("E_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("E_rst_tick", {31'd0, period_tick}, 32'd0);
    skip(3);
    reset = 1'b1;
    skip(1);
    chk("E_ready_after", {31'd0, cmd_ready}, 32'd1);
    wait_tick(n);
    skip(6);
    chk("E_no_restart", duty_out, 32'd0);
    skip(1);
    chk("E_busy_after", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
